multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle successor to the single-cycle opcode decoder. It sequences each RV32I instruction through
//  FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a req/ready handshake. It adds JAL/JALR,
//  SYSTEM halt, an optional memory timeout and a retired-instruction counter. It sits between the IR and
//  the datapath muxes/enables of the multi-cycle core.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for mem_ready in FETCH/MEM; 0 = timeout disabled
//  CNT_W        32  width of instret counter
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      synchronous, active-high reset
//  opcode         in   7      IR[6:0]; sampled in DECODE
//  branch_taken   in   1      branch comparator result, valid in EXEC
//  mem_ready      in   1      memory completes current request this cycle
//  stall          in   1      freeze FSM and suppress all strobes
//  mem_req        out  1      memory request (FETCH, MEM)
//  mem_src        out  1      address select: 0=PC, 1=ALU result
//  ir_write       out  1      load IR from memory read data
//  pc_write       out  1      update PC
//  pc_src         out  1      next PC select: 0=PC+4, 1=ALU target
//  branch         out  1      branch instruction in EXEC
//  MemRead        out  1      memory read strobe
//  MemWrite       out  1      memory write strobe
//  MemtoReg       out  2      rd source: 00=ALU, 01=mem data, 10=PC+4
//  ALUOp          out  2      00=Load/addr, 01=Branch, 10=Arith, 11=PASS
//  ALUSrc1        out  1      ALU A select: 0=rs1, 1=PC
//  ALUSrc         out  1      ALU B select: 0=rs2, 1=imm
//  RegWrite       out  1      register file write enable
//  halted         out  1      FSM in HALT (sticky until rst)
//  illegal_instr  out  1      HALT entered on unknown opcode
//  bus_error      out  1      HALT entered on memory timeout
//  instret        out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Outputs are Moore, decoded from state and opcode_q.
//  - Reset: state<=FETCH; opcode_q, instret, timeout count, illegal_instr, bus_error <= 0.
//    While rst=1, every combinational output is forced to 0.
//  - Reset mid-transaction abandons it; mem_req drops in the same cycle.
//  - FETCH: mem_req=1, mem_src=0, MemRead=1.
//    On mem_ready: ir_write=1 in the same cycle, then go to DECODE.
//  - DECODE: opcode_q<=opcode.
//    R 0110011, I 0010011, LUI 0110111, AUIPC 0010111, Load 0000011, Store 0100011, Branch 1100011,
//    JAL 1101111, JALR 1100111 go to EXEC.
//    SYSTEM 1110011 goes to HALT. Any other opcode goes to HALT and sets illegal_instr.
//  - EXEC ALU settings:
//    R: ALUOp=10, ALUSrc=0. I: ALUOp=10, ALUSrc=1. LUI: ALUOp=11, ALUSrc=1.
//    AUIPC, JAL: ALUOp=00, ALUSrc1=1, ALUSrc=1. JALR, Load, Store: ALUOp=00, ALUSrc=1.
//    Branch: ALUOp=01, branch=1.
//  - EXEC routing: Branch asserts pc_write=1 with pc_src=branch_taken, retires, goes to FETCH.
//    Load/Store go to MEM. All other opcodes go to WB.
//  - MEM: mem_req=1, mem_src=1, MemRead (Load) or MemWrite (Store) held until mem_ready.
//    On mem_ready: a Load goes to WB; a Store asserts pc_write=1, pc_src=0, retires, goes to FETCH.
//  - WB: RegWrite=1 and pc_write=1. Then retire and go to FETCH.
//    MemtoReg = 01 for Load, 10 for JAL/JALR, 00 otherwise.
//    pc_src = 1 for JAL/JALR, 0 otherwise.
//  - Retire: instret+1 on the retiring edge; wraps mod 2^CNT_W, no saturation.
//  - Timeout: counter clears on entry to FETCH/MEM and increments each cycle with mem_ready=0.
//    When it reaches MEM_TIMEOUT, go to HALT, set bus_error, drop mem_req.
//    mem_ready in that same cycle wins: no error.
//  - stall=1: state, opcode_q and timeout counter hold. mem_req, ir_write, pc_write, MemWrite and RegWrite are 0.
//    mem_ready is ignored while stalled; the memory must hold its response.
//  - HALT: all strobes 0 and halted=1 until rst. stall has no effect in HALT.
// TESTING
//  1. rst 2 cycles; opcode=0110011, mem_ready=1 -> states 0,1,2,4,0; RegWrite=1 only in WB; instret=1 after 4 cycles.
//  2. Load, mem_ready low 3 cycles in MEM -> MemRead held 4 MEM cycles; WB MemtoReg=01; instret+1.
//  3. Branch, branch_taken=1 -> EXEC pc_write=1, pc_src=1, RegWrite=0; 3 cycles to FETCH. Repeat with branch_taken=0 -> pc_src=0.
//  4. MEM_TIMEOUT=4, mem_ready=0 in FETCH -> bus_error=1, halted=1 after 4 cycles; held 20 cycles until rst.
//  5. opcode=0000000 -> illegal_instr=1, HALT. opcode=1110011 -> halted=1, illegal_instr=0. instret unchanged.
//  6. stall=1 for 2 WB cycles -> RegWrite=0, state held, then RegWrite=1 for 1 cycle. rst mid-MEM -> mem_req=0 same cycle, FETCH next.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Sequences each RV32I instruction through FETCH/DECODE/EXEC/
//               MEM/WB over one shared memory port, with halt, memory
//               timeout and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic             stall,
    output logic             mem_req,
    output logic             mem_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             branch,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUOp,
    output logic             ALUSrc1,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             halted,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd5;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    localparam int c_tmo_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // Last count value before the limit; the limit is hit on the cycle that would reach it.
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(MEM_TIMEOUT - 1);
    localparam logic c_tmo_en = (MEM_TIMEOUT != 0);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [6:0]         r_opcode_q;
    logic [CNT_W-1:0]   r_instret;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_illegal;
    logic               r_bus_error;

    logic w_retire;
    logic w_tmo_fire;
    logic w_set_illegal;
    logic w_tmo_hit;
    logic w_mem_wait;

    logic w_q_r, w_q_i, w_q_lui, w_q_auipc, w_q_load, w_q_store;
    logic w_q_branch, w_q_jal, w_q_jalr, w_q_jump;
    logic w_in_legal, w_in_system;

    assign w_q_r      = (r_opcode_q == c_op_r);
    assign w_q_i      = (r_opcode_q == c_op_i);
    assign w_q_lui    = (r_opcode_q == c_op_lui);
    assign w_q_auipc  = (r_opcode_q == c_op_auipc);
    assign w_q_load   = (r_opcode_q == c_op_load);
    assign w_q_store  = (r_opcode_q == c_op_store);
    assign w_q_branch = (r_opcode_q == c_op_branch);
    assign w_q_jal    = (r_opcode_q == c_op_jal);
    assign w_q_jalr   = (r_opcode_q == c_op_jalr);
    assign w_q_jump   = w_q_jal | w_q_jalr;

    assign w_in_system = (opcode == c_op_system);
    assign w_in_legal  = (opcode == c_op_r)     || (opcode == c_op_i)      ||
                         (opcode == c_op_lui)   || (opcode == c_op_auipc)  ||
                         (opcode == c_op_load)  || (opcode == c_op_store)  ||
                         (opcode == c_op_branch)|| (opcode == c_op_jal)    ||
                         (opcode == c_op_jalr);

    assign w_mem_wait = (r_state == c_st_fetch) || (r_state == c_st_mem);
    assign w_tmo_hit  = c_tmo_en && !mem_ready && (r_tmo_cnt == c_tmo_last);

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_fetch;
            r_opcode_q  <= 7'd0;
            r_instret   <= '0;
            r_tmo_cnt   <= '0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!stall && (r_state == c_st_decode)) begin
                r_opcode_q <= opcode;
            end
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
            if (w_tmo_fire) begin
                r_bus_error <= 1'b1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            // Every state change clears the count, so FETCH and MEM always start from zero.
            if (!stall) begin
                if (w_state_nxt != r_state) begin
                    r_tmo_cnt <= '0;
                end else if (w_mem_wait && !mem_ready) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_retire      = 1'b0;
        w_tmo_fire    = 1'b0;
        w_set_illegal = 1'b0;
        if (!stall) begin
            case (r_state)
                c_st_fetch: begin
                    if (mem_ready) begin
                        w_state_nxt = c_st_decode;
                    end else if (w_tmo_hit) begin
                        w_state_nxt = c_st_halt;
                        w_tmo_fire  = 1'b1;
                    end
                end
                c_st_decode: begin
                    if (w_in_legal) begin
                        w_state_nxt = c_st_exec;
                    end else begin
                        w_state_nxt   = c_st_halt;
                        w_set_illegal = !w_in_system;
                    end
                end
                c_st_exec: begin
                    if (w_q_branch) begin
                        w_state_nxt = c_st_fetch;
                        w_retire    = 1'b1;
                    end else if (w_q_load || w_q_store) begin
                        w_state_nxt = c_st_mem;
                    end else begin
                        w_state_nxt = c_st_wb;
                    end
                end
                c_st_mem: begin
                    if (mem_ready) begin
                        if (w_q_store) begin
                            w_state_nxt = c_st_fetch;
                            w_retire    = 1'b1;
                        end else begin
                            w_state_nxt = c_st_wb;
                        end
                    end else if (w_tmo_hit) begin
                        w_state_nxt = c_st_halt;
                        w_tmo_fire  = 1'b1;
                    end
                end
                c_st_wb: begin
                    w_state_nxt = c_st_fetch;
                    w_retire    = 1'b1;
                end
                c_st_halt: begin
                    w_state_nxt = c_st_halt;
                end
                default: begin
                    w_state_nxt = c_st_fetch;
                end
            endcase
        end
    end

    // Moore outputs; stall masks the strobes that would commit architectural state.
    always_comb begin
        mem_req  = 1'b0;
        mem_src  = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 2'b00;
        ALUOp    = 2'b00;
        ALUSrc1  = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            case (r_state)
                c_st_fetch: begin
                    mem_req  = !stall;
                    MemRead  = 1'b1;
                    ir_write = mem_ready && !stall;
                end
                c_st_exec: begin
                    if (w_q_branch) begin
                        ALUOp    = 2'b01;
                        branch   = 1'b1;
                        pc_write = !stall;
                        pc_src   = branch_taken;
                    end else if (w_q_r) begin
                        ALUOp = 2'b10;
                    end else if (w_q_i) begin
                        ALUOp  = 2'b10;
                        ALUSrc = 1'b1;
                    end else if (w_q_lui) begin
                        ALUOp  = 2'b11;
                        ALUSrc = 1'b1;
                    end else if (w_q_auipc || w_q_jal) begin
                        ALUSrc1 = 1'b1;
                        ALUSrc  = 1'b1;
                    end else if (w_q_jalr || w_q_load || w_q_store) begin
                        ALUSrc = 1'b1;
                    end
                end
                c_st_mem: begin
                    mem_req  = !stall;
                    mem_src  = 1'b1;
                    MemRead  = w_q_load;
                    MemWrite = w_q_store && !stall;
                    pc_write = w_q_store && mem_ready && !stall;
                end
                c_st_wb: begin
                    RegWrite = !stall;
                    pc_write = !stall;
                    pc_src   = w_q_jump;
                    MemtoReg = w_q_load ? 2'b01 : (w_q_jump ? 2'b10 : 2'b00);
                end
                c_st_halt: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign instret       = r_instret;
    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_error;

endmodule
`default_nettype wire
